if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
Instruction-fetch stage with a decoupled request/response instruction-memory interface. Issues sequential fetches with up to MAX_OUTSTANDING requests in flight. Buffers returned instructions in a QUEUE_DEPTH FIFO feeding decode. Squashes in-flight and buffered fetches on exception, ertn or branch redirect; sits between the redirect sources (EX/WB/CSR) and the decode stage.

Parameters:
RESET_PC, 32'h1c000000, first fetch address after reset
QUEUE_DEPTH, 4, instruction-buffer entries (power of two, >=2)
MAX_OUTSTANDING, 2, max accepted-but-unanswered requests (1..QUEUE_DEPTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ds_allowin  in  1  decode can accept an entry
fs_to_ds_valid  out  1  head entry valid to decode
fs_to_ds_bus  out  81  {excp_num[15:0], excp, inst[31:0], pc[31:0]} (bits 80:65, 64, 63:32, 31:0)
br_taken  in  1  branch redirect this cycle
br_target  in  32  branch target
excp_flush  in  1  exception redirect
ertn_flush  in  1  ertn redirect
eentry  in  32  exception entry
era  in  32  return address
inst_sram_req  out  1  request valid
inst_sram_wr  out  1  constant 0
inst_sram_size  out  2  constant 2'b10
inst_sram_addr  out  32  request address
inst_sram_addr_ok  in  1  request accepted
inst_sram_data_ok  in  1  in-order response valid
inst_sram_rdata  in  32  response data

Behaviour:
- Clock clk; reset is reset, synchronous, active-high. On reset: fetch_pc=RESET_PC, queue empty, outstanding=0, discard=0, halted=0; outputs fs_to_ds_valid=0, inst_sram_req=0.
- Redirect priority: excp_flush(eentry) > ertn_flush(era) > br_taken(br_target). redirect = any of the three.
- Issue: inst_sram_addr=fetch_pc. inst_sram_req = !reset && !halted && !redirect && fetch_pc[1:0]==0 && outstanding<MAX_OUTSTANDING && (queue_count+outstanding)<QUEUE_DEPTH. The credit check guarantees every response has a slot.
- On req&&addr_ok: fetch_pc+=4, outstanding+=1. A per-request PC FIFO, depth MAX_OUTSTANDING, records the PC.
- On data_ok: outstanding-=1 and PC FIFO pops. If discard>0: discard-=1, data dropped. Else {pc, rdata, excp=0, num=0} is pushed. Simultaneous handshake and data_ok leave outstanding unchanged.
- Redirect cycle: fetch_pc<=target; queue cleared; pc FIFO cleared; halted<=0.
- Redirect cycle, discard bookkeeping: discard<=discard+outstanding-(data_ok?1:0). data_ok in the redirect cycle is always dropped. req is forced low that cycle, so no handshake is counted.
- ADEF: when fetch_pc[1:0]!=0, !halted and the queue has a free credit, push {fetch_pc, 32'h0, excp=1, num=16'h4000} without a memory request, then halted<=1. This waits for outstanding==0 && discard==0 so ordering is kept. Halted clears only on redirect.
- Output: fs_to_ds_valid = queue non-empty && !excp_flush && !ertn_flush. Pop when fs_to_ds_valid && ds_allowin.
- Push and pop in the same cycle are legal when full. Pointers wrap modulo QUEUE_DEPTH.
- Reset mid-operation: all counters zeroed. Responses to pre-reset requests are the memory's responsibility (memory is reset together).

Optional Feature:
IF_BYPASS_EN
- Defined: when the queue is empty, a non-discarded data_ok with ds_allowin drives fs_to_ds_valid and the bus combinationally from rdata in the same cycle, and the entry is not written.
- Undefined: responses always enter the queue; earliest decode visibility is the cycle after data_ok.

Decomposition:
- Shared package holds:
  - FS_TO_DS_BUS_WD=81
  - field offsets
  - ECODE bit positions (ADEF=bit 14)
  - RESET_PC default
  - constant SIZE_WORD=2'b10
- Sub-module fetch_fifo(WIDTH, DEPTH): synchronous FIFO with push, pop, clear, count, full and empty. It is instantiated twice: instruction queue (WIDTH 81) and PC FIFO (WIDTH 32).

Test Plan:
- Reset, addr_ok=1, data_ok one cycle later, ds_allowin=1 -> addrs 1c000000, 1c000004, ...; decode sees pc 1c000000 with matching rdata in order.
- ds_allowin=0, QUEUE_DEPTH=4 -> exactly 4 handshakes total, then req low. Raising ds_allowin resumes fetch with no loss or duplication.
- Two requests outstanding, br_taken target 1c000100 -> both responses dropped (discard 2->0); next decode pc=1c000100; queue empty after redirect.
- excp_flush and br_taken same cycle, eentry=1c008000 -> next fetch 1c008000.
- br_target=1c000102 -> no request for it; single entry with excp=1, num=16'h4000, inst=0; req stays low until excp_flush.
- IF_BYPASS_EN, empty queue, data_ok with ds_allowin=1 -> fs_to_ds_valid same cycle. Without the macro -> valid one cycle later.

Source files
------------

// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue: decode bus layout, exception
// codes, reset PC and memory request constants.
package if_fetch_queue_pkg;

  localparam int FS_TO_DS_BUS_WD = 81;

  // Field offsets inside fs_to_ds_bus
  localparam int BUS_PC_LSB     = 0;
  localparam int BUS_INST_LSB   = 32;
  localparam int BUS_EXCP_BIT   = 64;
  localparam int BUS_NUM_LSB    = 65;

  localparam int ECODE_ADEF = 14;
  localparam logic [15:0] EXCP_NUM_ADEF = 16'h0001 << ECODE_ADEF;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  localparam logic [1:0]  SIZE_WORD        = 2'b10;

  typedef struct packed {
    logic [15:0] excp_num;
    logic        excp;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_entry_t;

  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_BR,
    REDIR_ERTN,
    REDIR_EXCP
  } redir_src_e;

  function automatic fs_entry_t make_entry(input logic [31:0] pc, input logic [31:0] inst,
                                           input logic excp, input logic [15:0] num);
    fs_entry_t e;
    e.excp_num = num;
    e.excp     = excp;
    e.inst     = inst;
    e.pc       = pc;
    return e;
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface if_fetch_queue_if;
  // A request is accepted on a cycle where req && addr_ok; req may only depend on
  // fetch-side state, never on addr_ok. Responses arrive in request order, one per
  // cycle with data_ok high, and are never back-pressured.
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, addr, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, addr, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/if_fetch_queue_fetch_fifo.sv
// Synchronous FIFO with clear; push while full is accepted only together with a pop.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_r;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count_r == '0);
  assign full     = (count_r == CW'(DEPTH));
  assign count    = count_r;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: sequential fetch with bounded outstanding requests, an
// instruction queue toward decode, redirect squashing. Option macro: IF_BYPASS_EN.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  input  logic                       br_taken,
  input  logic [31:0]                br_target,
  input  logic                       excp_flush,
  input  logic                       ertn_flush,
  input  logic [31:0]                eentry,
  input  logic [31:0]                era,
  if_fetch_queue_if.master           inst_sram
);

  localparam int QCW = $clog2(QUEUE_DEPTH + 1);
  localparam int PCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW  = QCW + 1;
  // Discarded responses can pile up across back-to-back redirects, so this counter
  // is wider than the live outstanding count.
  localparam int DW  = 8;

  logic [31:0]    fetch_pc;
  logic           halted;
  logic [DW-1:0]  discard;

  redir_src_e     redir_src;
  logic [31:0]    redir_target;
  logic           redirect;

  logic           req;
  logic           handshake;
  logic           live_resp;
  logic           bypass;
  logic           adef_fire;
  logic           credit_ok;
  logic [SW-1:0]  credit_used;

  logic [31:0]    resp_pc;
  logic [PCW-1:0] pc_count;
  logic           pc_full;
  logic           pc_empty;

  fs_entry_t      resp_entry;
  fs_entry_t      adef_entry;
  fs_entry_t      q_push_data;
  fs_entry_t      q_head;
  fs_entry_t      out_entry;
  logic           q_push;
  logic           q_pop;
  logic [QCW-1:0] q_count;
  logic           q_full;
  logic           q_empty;

  always_comb begin
    redir_src    = REDIR_NONE;
    redir_target = fetch_pc;
    if (excp_flush) begin
      redir_src    = REDIR_EXCP;
      redir_target = eentry;
    end else if (ertn_flush) begin
      redir_src    = REDIR_ERTN;
      redir_target = era;
    end else if (br_taken) begin
      redir_src    = REDIR_BR;
      redir_target = br_target;
    end
  end

  assign redirect = (redir_src != REDIR_NONE);

  // Live outstanding requests are exactly the PCs waiting in the PC FIFO; requests
  // squashed by a redirect move into the discard count instead.
  assign credit_used = SW'(q_count) + SW'(pc_count);
  assign credit_ok   = credit_used < SW'(QUEUE_DEPTH);

  assign req = !reset && !halted && !redirect && (fetch_pc[1:0] == 2'b00)
             && !pc_full && credit_ok;

  assign inst_sram.req  = req;
  assign inst_sram.wr   = 1'b0;
  assign inst_sram.size = SIZE_WORD;
  assign inst_sram.addr = fetch_pc;

  assign handshake = req && inst_sram.addr_ok;
  assign live_resp = inst_sram.data_ok && !redirect && (discard == '0);

  // Misaligned PC: report ADEF once all older fetches have resolved, then stall.
  assign adef_fire = !redirect && !halted && (fetch_pc[1:0] != 2'b00)
                   && pc_empty && (discard == '0) && !q_full;

  assign resp_entry = make_entry(resp_pc, inst_sram.rdata, 1'b0, 16'h0000);
  assign adef_entry = make_entry(fetch_pc, 32'h0000_0000, 1'b1, EXCP_NUM_ADEF);

`ifdef IF_BYPASS_EN
  assign bypass = live_resp && q_empty && ds_allowin;
`else
  assign bypass = 1'b0;
`endif

  assign q_push      = (live_resp && !bypass) || adef_fire;
  assign q_push_data = adef_fire ? adef_entry : resp_entry;
  assign out_entry   = bypass ? resp_entry : q_head;

  assign fs_to_ds_valid = !reset && ((!q_empty && !excp_flush && !ertn_flush) || bypass);
  assign fs_to_ds_bus   = out_entry;
  assign q_pop          = !q_empty && fs_to_ds_valid && ds_allowin;

  fetch_fifo #(.WIDTH(FS_TO_DS_BUS_WD), .DEPTH(QUEUE_DEPTH)) u_inst_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .pop_data  (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (handshake),
    .push_data (fetch_pc),
    .pop       (live_resp),
    .pop_data  (resp_pc),
    .count     (pc_count),
    .full      (pc_full),
    .empty     (pc_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      halted   <= 1'b0;
      discard  <= '0;
    end else if (redirect) begin
      fetch_pc <= redir_target;
      halted   <= 1'b0;
      discard  <= discard + DW'(pc_count) - DW'(inst_sram.data_ok);
    end else begin
      if (handshake) fetch_pc <= fetch_pc + 32'd4;
      if (adef_fire) halted <= 1'b1;
      if (inst_sram.data_ok && (discard != '0)) discard <= discard - 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: queue-based reference model, random memory
// latency, directed redirect/ADEF scenarios and a randomized soak.
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  localparam int QD = 4;
  localparam int MO = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [80:0] fs_to_ds_bus;
  logic        br_taken;
  logic [31:0] br_target;
  logic        excp_flush;
  logic        ertn_flush;
  logic [31:0] eentry;
  logic [31:0] era;

  if_fetch_queue_if inst_sram ();

  if_fetch_queue #(.RESET_PC(32'h1c00_0000), .QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MO)) dut (
    .clk            (clk),
    .reset          (reset),
    .ds_allowin     (ds_allowin),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .excp_flush     (excp_flush),
    .ertn_flush     (ertn_flush),
    .eentry         (eentry),
    .era            (era),
    .inst_sram      (inst_sram)
  );

  // ---------------- reference model state ----------------
  logic [31:0] m_pc;
  bit          m_halted;
  logic [31:0] m_live[$];
  int          m_stale;
  logic [80:0] exp_q[$];

  // memory: accepted addresses with the cycle they become answerable
  logic [31:0] mem_addr_q[$];
  int          mem_rdy_q[$];

  int  cyc;
  int  checks, passes;
  int  p_allow, p_aok, p_dok, lat_max, p_redir, p_rst;
  bit  hold;
  int  hs_cnt, pop_cnt;
  logic [31:0] hs_log[$];
  logic [80:0] last_pop;
  int  first_valid_cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ 32'h3c6e_f372) * 32'h9e37_79b1) + 32'd1;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = 32'h1c00_0000 + 32'($urandom_range(0, 1023)) * 32'd4;
    if ($urandom_range(0, 9) == 0) t = t + 32'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_pc = 32'h1c00_0000;
    m_halted = 0;
    m_live.delete();
    m_stale = 0;
    exp_q.delete();
    mem_addr_q.delete();
    mem_rdy_q.delete();
  endtask

  // ---------------- one clock cycle: drive, compare, advance model ----------------
  task automatic step();
    bit redir, live_resp, byp, exp_req, exp_valid, pop, adef;
    logic [31:0] tgt, rpc;
    logic [80:0] exp_bus;
    cyc++;
    if (p_rst > 0) reset = ($urandom_range(0, 999) < p_rst);
    if (p_redir > 0) begin
      excp_flush = 0; ertn_flush = 0; br_taken = 0;
      if ($urandom_range(0, 99) < p_redir) begin
        case ($urandom_range(0, 3))
          0: excp_flush = 1;
          1: ertn_flush = 1;
          2: br_taken = 1;
          default: begin excp_flush = 1; br_taken = 1; ertn_flush = 1'($urandom_range(0, 1)); end
        endcase
      end
      eentry = rand_target(); era = rand_target(); br_target = rand_target();
    end
    ds_allowin = ($urandom_range(0, 99) < p_allow);
    inst_sram.addr_ok = ($urandom_range(0, 99) < p_aok);
    inst_sram.data_ok = !reset && !hold && (mem_addr_q.size() > 0) && (mem_rdy_q[0] <= cyc)
                        && ($urandom_range(0, 99) < p_dok);
    inst_sram.rdata = inst_sram.data_ok ? mem_word(mem_addr_q[0]) : $urandom;
    #2;

    if (fs_to_ds_valid && first_valid_cyc == 0) first_valid_cyc = cyc;
    if (inst_sram.req && inst_sram.addr_ok) begin
      hs_cnt++;
      hs_log.push_back(inst_sram.addr);
    end
    if (fs_to_ds_valid && ds_allowin) begin
      pop_cnt++;
      last_pop = fs_to_ds_bus;
    end

    chk("wr_const", {80'h0, inst_sram.wr}, 81'h0);
    chk("size_const", {79'h0, inst_sram.size}, 81'h2);

    if (reset) begin
      chk("req_in_reset", {80'h0, inst_sram.req}, 81'h0);
      chk("valid_in_reset", {80'h0, fs_to_ds_valid}, 81'h0);
      model_reset();
    end else begin
      redir = excp_flush || ertn_flush || br_taken;
      tgt = excp_flush ? eentry : (ertn_flush ? era : br_target);
      live_resp = inst_sram.data_ok && !redir && (m_stale == 0);
      rpc = (m_live.size() > 0) ? m_live[0] : 32'h0;
`ifdef IF_BYPASS_EN
      byp = live_resp && (exp_q.size() == 0) && ds_allowin;
`else
      byp = 0;
`endif
      exp_req = !m_halted && !redir && (m_pc[1:0] == 2'b00) && (m_live.size() < MO)
                && (exp_q.size() + m_live.size() < QD);
      exp_valid = ((exp_q.size() > 0) && !excp_flush && !ertn_flush) || byp;
      exp_bus = (exp_q.size() > 0) ? exp_q[0] : {16'h0, 1'b0, inst_sram.rdata, rpc};

      chk("req", {80'h0, inst_sram.req}, {80'h0, exp_req});
      if (exp_req) chk("addr", {49'h0, inst_sram.addr}, {49'h0, m_pc});
      chk("valid", {80'h0, fs_to_ds_valid}, {80'h0, exp_valid});
      if (exp_valid) chk("bus", fs_to_ds_bus, exp_bus);

      if (redir) begin
        m_stale = m_stale + m_live.size() - (inst_sram.data_ok ? 1 : 0);
        m_live.delete();
        exp_q.delete();
        m_pc = tgt;
        m_halted = 0;
      end else begin
        pop  = (exp_q.size() > 0) && exp_valid && ds_allowin;
        adef = (m_pc[1:0] != 2'b00) && !m_halted && (m_live.size() == 0) && (m_stale == 0)
               && (exp_q.size() < QD);
        if (pop) void'(exp_q.pop_front());
        if (inst_sram.data_ok) begin
          if (m_stale > 0) m_stale--;
          else begin
            rpc = m_live.pop_front();
            if (!byp) exp_q.push_back({16'h0, 1'b0, inst_sram.rdata, rpc});
          end
        end
        if (adef) begin
          exp_q.push_back({16'h4000, 1'b1, 32'h0, m_pc});
          m_halted = 1;
        end
        if (exp_req && inst_sram.addr_ok) begin
          m_live.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end

      if (inst_sram.data_ok) begin
        void'(mem_addr_q.pop_front());
        void'(mem_rdy_q.pop_front());
      end
      if (inst_sram.req && inst_sram.addr_ok) begin
        mem_addr_q.push_back(inst_sram.addr);
        mem_rdy_q.push_back(cyc + $urandom_range(1, lat_max));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    repeat (n) step();
    reset = 0;
  endtask

  task automatic clear_redirects();
    br_taken = 0; excp_flush = 0; ertn_flush = 0;
  endtask

  // ---------------- directed scenarios + random soak ----------------
  initial begin
    int base;
    checks = 0; passes = 0; cyc = 0; hs_cnt = 0; pop_cnt = 0; first_valid_cyc = 0;
    last_pop = '0;
    reset = 1; ds_allowin = 0; clear_redirects();
    br_target = 32'h0; eentry = 32'h0; era = 32'h0;
    inst_sram.addr_ok = 0; inst_sram.data_ok = 0; inst_sram.rdata = 32'h0;
    p_allow = 0; p_aok = 100; p_dok = 100; lat_max = 1; p_redir = 0; p_rst = 0; hold = 0;
    model_reset();
    @(posedge clk);
    #1;

    // decode stalled: exactly QUEUE_DEPTH handshakes, then release
    do_reset(2);
    hs_cnt = 0; hs_log.delete();
    repeat (15) step();
    chk("stall_handshakes", 81'(hs_cnt), 81'd4);
    chk("first_addr", {49'h0, hs_log[0]}, {49'h0, 32'h1c00_0000});
    chk("second_addr", {49'h0, hs_log[1]}, {49'h0, 32'h1c00_0004});
    p_allow = 100; pop_cnt = 0;
    for (int i = 0; i < 10 && pop_cnt == 0; i++) step();
    chk("first_pop_pc", {49'h0, last_pop[31:0]}, {49'h0, 32'h1c00_0000});
    chk("first_pop_inst", {49'h0, last_pop[63:32]}, {49'h0, mem_word(32'h1c00_0000)});
    repeat (20) step();

    // decode visibility latency of the first response after reset
    do_reset(1);
    base = cyc; first_valid_cyc = 0;
    repeat (6) step();
`ifdef IF_BYPASS_EN
    chk("first_valid_latency", 81'(first_valid_cyc - base - 1), 81'd1);
`else
    chk("first_valid_latency", 81'(first_valid_cyc - base - 1), 81'd2);
`endif
    repeat (10) step();

    // branch with two requests in flight: both responses dropped
    hold = 1;
    for (int i = 0; i < 10 && m_live.size() != 2; i++) step();
    chk("live_before_br", 81'(m_live.size()), 81'd2);
    br_taken = 1; br_target = 32'h1c00_0100;
    step();
    clear_redirects();
    chk("stale_after_br", 81'(m_stale), 81'd2);
    hold = 0; pop_cnt = 0;
    for (int i = 0; i < 20 && pop_cnt == 0; i++) step();
    chk("pop_after_br_pc", {49'h0, last_pop[31:0]}, {49'h0, 32'h1c00_0100});
    chk("stale_drained", 81'(m_stale), 81'd0);

    // exception wins over a simultaneous branch
    excp_flush = 1; eentry = 32'h1c00_8000; br_taken = 1; br_target = 32'h1c00_0200;
    step();
    clear_redirects();
    hs_log.delete();
    for (int i = 0; i < 20 && hs_log.size() == 0; i++) step();
    chk("excp_priority_addr", {49'h0, (hs_log.size() > 0) ? hs_log[0] : 32'h0}, {49'h0, 32'h1c00_8000});

    // misaligned branch target raises ADEF and stalls fetch
    br_taken = 1; br_target = 32'h1c00_0102;
    step();
    clear_redirects();
    pop_cnt = 0;
    for (int i = 0; i < 30 && pop_cnt == 0; i++) step();
    chk("adef_entry", last_pop, {16'h4000, 1'b1, 32'h0, 32'h1c00_0102});
    hs_cnt = 0;
    repeat (10) step();
    chk("adef_req_low", 81'(hs_cnt), 81'd0);
    excp_flush = 1; eentry = 32'h1c00_8000;
    step();
    clear_redirects();
    hs_log.delete();
    for (int i = 0; i < 20 && hs_log.size() == 0; i++) step();
    chk("adef_recover_addr", {49'h0, (hs_log.size() > 0) ? hs_log[0] : 32'h0}, {49'h0, 32'h1c00_8000});

    // randomized soak
    p_allow = 70; p_aok = 60; p_dok = 60; lat_max = 3; p_redir = 4; p_rst = 3;
    repeat (2000) step();
    p_redir = 0; p_rst = 0; reset = 0; clear_redirects();
    p_allow = 100; p_aok = 100; p_dok = 100;
    repeat (30) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
